// File: rtl/blur_pkg.sv
// Shared definitions for the 3x3 blur window controller:
// default pixel width, window slot indices and FSM state encoding.
package blur_pkg;

  localparam int PIX_W_DEF = 8;

  // slot k = 3*row + col, row 0 oldest, col 0 leftmost
  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W02 = 2;
  localparam int W10 = 3;
  localparam int W11 = 4;
  localparam int W12 = 5;
  localparam int W20 = 6;
  localparam int W21 = 7;
  localparam int W22 = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/blur_window_ctrl_line_buffer.sv
// One-row pixel store: DEPTH x WIDTH, read-before-write at one address.
// Ports: clk, we, addr, wdata in; rdata out (old content of addr).
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // async read returns the value before this cycle's write lands
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/blur_window_ctrl.sv
// Frame sequencer and 3x3 window generator for the gaussian blur kernel.
// Ports: clk, rst (sync, high), start, in_valid/in_ready/in_pixel stream,
// win_valid/win_pixels/win_row/win_col window out, busy, done.
module blur_window_ctrl
  import blur_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             win_valid,
  output logic [9*PIX_W-1:0] win_pixels,
  output logic [15:0]      win_row,
  output logic [15:0]      win_col,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(IMG_W);

  state_t state;
  logic [15:0] row;
  logic [15:0] col;
  logic [8:0][PIX_W-1:0] sr;
  logic [8:0][PIX_W-1:0] shifted;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic accept;
  logic last_col;
  logic last_row;
  logic emit;

  assign accept   = in_valid & in_ready;
  assign last_col = (col == 16'(IMG_W - 1));
  assign last_row = (row == 16'(IMG_H - 1));
  // c>=2 keeps every window inside a single row band
  assign emit     = accept & (row >= 16'd2) & (col >= 16'd2);

  // lb0 holds row r-2, lb1 holds row r-1 at each column
  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W),
    .AW   (AW)
  ) lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col[AW-1:0]),
    .wdata(lb1_rd),
    .rdata(lb0_rd)
  );

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W),
    .AW   (AW)
  ) lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col[AW-1:0]),
    .wdata(in_pixel),
    .rdata(lb1_rd)
  );

  always_comb begin
    shifted      = sr;
    shifted[W00] = sr[W01];
    shifted[W01] = sr[W02];
    shifted[W02] = lb0_rd;
    shifted[W10] = sr[W11];
    shifted[W11] = sr[W12];
    shifted[W12] = lb1_rd;
    shifted[W20] = sr[W21];
    shifted[W21] = sr[W22];
    shifted[W22] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      row        <= '0;
      col        <= '0;
      sr         <= '0;
      win_valid  <= 1'b0;
      win_pixels <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      if (accept) sr <= shifted;
      if (emit) begin
        win_valid  <= 1'b1;
        win_pixels <= shifted;
        win_row    <= row - 16'd1;
        win_col    <= col - 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + 16'd1;
              if (last_row) begin
                state    <= DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                row      <= '0;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blur_window_ctrl.sv
// Directed bench for blur_window_ctrl: 4x4 and 8x3 frames.
// Windows are checked against a raster model pixel = 4r+c.
module tb_blur_window_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start4, valid4, rdy4, wv4, busy4, done4;
  logic [7:0] pix4;
  logic [71:0] wp4;
  logic [15:0] wr4, wc4;

  logic start8, valid8, rdy8, wv8, busy8, done8;
  logic [7:0] pix8;
  logic [71:0] wp8;
  logic [15:0] wr8, wc8;

  blur_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .in_valid(valid4), .in_ready(rdy4), .in_pixel(pix4),
    .win_valid(wv4), .win_pixels(wp4),
    .win_row(wr4), .win_col(wc4),
    .busy(busy4), .done(done4)
  );

  blur_window_ctrl #(.IMG_W(8), .IMG_H(3), .PIX_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .in_valid(valid8), .in_ready(rdy8), .in_pixel(pix8),
    .win_valid(wv8), .win_pixels(wp8),
    .win_row(wr8), .win_col(wc8),
    .busy(busy8), .done(done8)
  );

  int total = 0;
  int bad = 0;

  logic [71:0] qp[$];
  int qr[$];
  int qc[$];
  bit qd[$];
  logic [71:0] q8[$];
  bit q8d[$];
  int dn4 = 0;
  int orphan = 0;
  bit prev_acc4 = 1'b0;

  always @(negedge clk) begin
    if (wv4) begin
      qp.push_back(wp4);
      qr.push_back(int'(wr4));
      qc.push_back(int'(wc4));
      qd.push_back(done4);
      if (!prev_acc4) orphan++;
    end
    if (done4) dn4++;
    prev_acc4 = valid4 && rdy4;
    if (wv8) begin
      q8.push_back(wp8);
      q8d.push_back(done8);
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(4*(r-1+i) + (c-1+j));
    return w;
  endfunction

  function automatic int blur(input logic [71:0] w);
    int s;
    s = int'(w[7:0]) + 2*int'(w[15:8]) + int'(w[23:16])
      + 2*int'(w[31:24]) + 4*int'(w[39:32]) + 2*int'(w[47:40])
      + int'(w[55:48]) + 2*int'(w[63:56]) + int'(w[71:64]);
    return s >> 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    qp.delete(); qr.delete(); qc.delete(); qd.delete();
  endtask

  task automatic start_frame4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // feed pixels 0..stop_n-1; optional start pulse at index mid
  task automatic feed4(input int pct, input int mid, input int stop_n);
    int idx = 0;
    int guard = 0;
    bit v, acc;
    while (idx < stop_n && guard < 400) begin
      v = ($urandom_range(0, 99) >= pct);
      valid4 = v;
      pix4 = 8'(idx);
      start4 = (idx == mid);
      @(negedge clk);
      acc = v && rdy4;
      tick();
      if (acc) idx++;
      guard++;
    end
    valid4 = 1'b0;
    start4 = 1'b0;
    chk("feed4_timeout", 72'(guard < 400), 72'(1));
  endtask

  task automatic check_frame4(input string tag);
    int r, c;
    repeat (3) tick();
    chk({tag, "_count"}, 72'(qp.size()), 72'(4));
    for (int k = 0; k < 4 && k < qp.size(); k++) begin
      r = 1 + k / 2;
      c = 1 + k % 2;
      chk($sformatf("%s_win%0d", tag, k), qp[k], exp_win(r, c));
      chk($sformatf("%s_row%0d", tag, k), 72'(qr[k]), 72'(r));
      chk($sformatf("%s_col%0d", tag, k), 72'(qc[k]), 72'(c));
      chk($sformatf("%s_done%0d", tag, k), 72'(qd[k]), 72'(k == 3));
    end
  endtask

  initial begin
    int d0;
    int idx;
    int guard;
    bit rdy_seen;
    bit acc;
    rst = 1'b1;
    start4 = 0; valid4 = 0; pix4 = 0;
    start8 = 0; valid8 = 0; pix8 = 0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 72'(rdy4), 72'(0));
    chk("rst_busy", 72'(busy4), 72'(0));
    chk("rst_done", 72'(done4), 72'(0));
    chk("rst_win_valid", 72'(wv4), 72'(0));
    chk("rst_win_pixels", wp4, 72'(0));
    chk("rst_win_rowcol", 72'({wr4, wc4}), 72'(0));
    tick();

    // 1: back-to-back frame
    clr();
    d0 = dn4;
    start_frame4();
    chk("t1_busy_run", 72'(busy4), 72'(1));
    feed4(0, -1, 16);
    check_frame4("t1");
    if (qp.size() > 0)
      chk("t1_blur_first", 72'(blur(qp[0])), 72'(5));
    chk("t1_done_pulses", 72'(dn4 - d0), 72'(1));
    chk("t1_busy_after", 72'(busy4), 72'(0));

    // 2: ~40% bubbles
    clr();
    orphan = 0;
    start_frame4();
    feed4(40, -1, 16);
    check_frame4("t2");
    chk("t2_orphan", 72'(orphan), 72'(0));

    // 3: start during RUN ignored, then restart after done
    clr();
    start_frame4();
    feed4(0, 5, 16);
    check_frame4("t3a");
    repeat (2) tick();
    chk("t3_busy_idle", 72'(busy4), 72'(0));
    clr();
    start_frame4();
    feed4(0, -1, 16);
    check_frame4("t3b");

    // 4: reset after pixel (2,1)
    clr();
    start_frame4();
    feed4(0, -1, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_win_valid", 72'(wv4), 72'(0));
    chk("t4_busy", 72'(busy4), 72'(0));
    chk("t4_in_ready", 72'(rdy4), 72'(0));
    chk("t4_win_pixels", wp4, 72'(0));
    tick();
    clr();
    start_frame4();
    feed4(0, -1, 16);
    check_frame4("t4");

    // 6: in_valid held in IDLE without start
    clr();
    rdy_seen = 1'b0;
    valid4 = 1'b1;
    pix4 = 8'h55;
    repeat (20) begin
      @(negedge clk);
      if (rdy4) rdy_seen = 1'b1;
      tick();
    end
    valid4 = 1'b0;
    chk("t6_in_ready", 72'(rdy_seen), 72'(0));
    chk("t6_no_window", 72'(qp.size()), 72'(0));
    chk("t6_busy", 72'(busy4), 72'(0));
    start_frame4();
    feed4(0, -1, 16);
    check_frame4("t6");

    // 5: 8x3 frame of 0xFF
    q8.delete();
    q8d.delete();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    idx = 0;
    guard = 0;
    valid8 = 1'b1;
    pix8 = 8'hFF;
    while (idx < 24 && guard < 200) begin
      @(negedge clk);
      acc = rdy8;
      tick();
      if (acc) idx++;
      guard++;
    end
    valid8 = 1'b0;
    chk("t5_timeout", 72'(guard < 200), 72'(1));
    repeat (3) tick();
    chk("t5_count", 72'(q8.size()), 72'(6));
    for (int k = 0; k < q8.size(); k++) begin
      chk($sformatf("t5_win%0d", k), q8[k], {72{1'b1}});
      chk($sformatf("t5_blur%0d", k), 72'(blur(q8[k])), 72'(255));
      chk($sformatf("t5_done%0d", k), 72'(q8d[k]),
          72'(k == q8.size() - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
